bpu_inflight_ctrl: RTL and testbench

Tracks every gshare prediction from fetch until its branch resolves in EX. Queues the predictor index, predicted direction and recovery PC per in-flight branch, and drives the gshare predictor's training port in resolution order. Detects mispredictions, then issues a one-cycle flush with the redirect PC to the fetch stage. Sits between the fetch stage, the EX stage and the gshare predictor, and replaces the ad-hoc pipelining of the prediction index through the pipeline registers.

---
 rtl/bpu_inflight_ctrl.sv | 165 ++++++++++++++++
 tb/tb_bpu_inflight_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_inflight_ctrl.sv
// rtl/bpu_inflight_ctrl.sv - in-flight branch tracker between fetch, EX and the gshare predictor
//
// Purpose: queues {pred, idx, alt_pc} for every predicted branch from fetch
// until EX resolves it (oldest first). It trains the predictor in resolution
// order, and on a misprediction issues a one-cycle flush with the recovery PC.
// Optional feature: define BPU_PERF_CNT_EN to build saturating
// resolved/mispredicted branch counters; otherwise both outputs read 0.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   f_branch_i        push request from fetch (predicted branch)
//   f_pred_i          predicted direction
//   f_idx_i           predictor index used for the prediction
//   f_alt_pc_i        recovery PC if the prediction turns out wrong
//   f_stall_o         queue full, fetch must hold
//   ex_resolve_i      oldest branch resolves (pop)
//   ex_taken_i        actual direction
//   upd_valid_o       predictor training strobe
//   upd_taken_o       predictor training direction
//   upd_idx_o         predictor training index
//   flush_o           one-cycle misprediction flush
//   redirect_pc_o     fetch restart PC, held until the next misprediction
//   err_o             sticky: resolve seen with an empty queue
//   br_cnt_o          resolved-branch count
//   mp_cnt_o          misprediction count
module bpu_inflight_ctrl #(
  parameter int GSHARE_BITS_NUM = 3,
  parameter int PC_WIDTH        = 10,
  parameter int DEPTH           = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       f_branch_i,
  input  logic                       f_pred_i,
  input  logic [GSHARE_BITS_NUM-1:0] f_idx_i,
  input  logic [PC_WIDTH-1:0]        f_alt_pc_i,
  output logic                       f_stall_o,
  input  logic                       ex_resolve_i,
  input  logic                       ex_taken_i,
  output logic                       upd_valid_o,
  output logic                       upd_taken_o,
  output logic [GSHARE_BITS_NUM-1:0] upd_idx_o,
  output logic                       flush_o,
  output logic [PC_WIDTH-1:0]        redirect_pc_o,
  output logic                       err_o,
  output logic [15:0]                br_cnt_o,
  output logic [15:0]                mp_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t state, state_nxt;

  logic                       pred_q [DEPTH];
  logic [GSHARE_BITS_NUM-1:0] idx_q  [DEPTH];
  logic [PC_WIDTH-1:0]        alt_q  [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic push, pop, mispredict, empty_resolve;

  // Stall looks only at the registered count, so a same-cycle pop never
  // lets a push through a full queue.
  assign f_stall_o     = (count == FULL_CNT);
  assign pop           = (state == RUN) && ex_resolve_i && (count != '0);
  assign empty_resolve = (state == RUN) && ex_resolve_i && (count == '0);
  assign mispredict    = pop && (ex_taken_i != pred_q[rd_ptr]);
  assign push          = f_branch_i && !f_stall_o && (state == RUN) && !mispredict;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  // Next-state logic: FLUSH lasts exactly one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (mispredict) state_nxt = FLUSH;
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Output logic
  always_comb begin
    flush_o = 1'b0;
    if (state == FLUSH) flush_o = 1'b1;
  end

  // Queue payload; never needs reset because count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      pred_q[wr_ptr] <= f_pred_i;
      idx_q[wr_ptr]  <= f_idx_i;
      alt_q[wr_ptr]  <= f_alt_pc_i;
    end
  end

  // Queue control. A misprediction wipes everything younger than the head,
  // which is all wrong-path, so the whole queue restarts from empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      redirect_pc_o <= '0;
    end else if (mispredict) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      redirect_pc_o <= alt_q[rd_ptr];
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Predictor training: one-cycle strobe per pop, zeros otherwise
  always_ff @(posedge clk) begin
    if (!rst) begin
      upd_valid_o <= 1'b0;
      upd_taken_o <= 1'b0;
      upd_idx_o   <= '0;
      err_o       <= 1'b0;
    end else begin
      upd_valid_o <= pop;
      upd_taken_o <= pop && ex_taken_i;
      upd_idx_o   <= pop ? idx_q[rd_ptr] : '0;
      if (empty_resolve) err_o <= 1'b1;
    end
  end

`ifdef BPU_PERF_CNT_EN
  logic [15:0] br_cnt, mp_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else begin
      if (pop && br_cnt != 16'hFFFF)        br_cnt <= br_cnt + 16'd1;
      if (mispredict && mp_cnt != 16'hFFFF) mp_cnt <= mp_cnt + 16'd1;
    end
  end

  assign br_cnt_o = br_cnt;
  assign mp_cnt_o = mp_cnt;
`else
  assign br_cnt_o = 16'h0000;
  assign mp_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_bpu_inflight_ctrl.sv
// tb/tb_bpu_inflight_ctrl.sv - directed self-checking bench for bpu_inflight_ctrl
module tb_bpu_inflight_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_branch_i;
  logic        f_pred_i;
  logic [2:0]  f_idx_i;
  logic [9:0]  f_alt_pc_i;
  logic        f_stall_o;
  logic        ex_resolve_i;
  logic        ex_taken_i;
  logic        upd_valid_o;
  logic        upd_taken_o;
  logic [2:0]  upd_idx_o;
  logic        flush_o;
  logic [9:0]  redirect_pc_o;
  logic        err_o;
  logic [15:0] br_cnt_o;
  logic [15:0] mp_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef BPU_PERF_CNT_EN
  localparam logic [31:0] EXP_BR = 32'd5;
  localparam logic [31:0] EXP_MP = 32'd2;
`else
  localparam logic [31:0] EXP_BR = 32'd0;
  localparam logic [31:0] EXP_MP = 32'd0;
`endif

  bpu_inflight_ctrl #(.GSHARE_BITS_NUM(3), .PC_WIDTH(10), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .f_branch_i(f_branch_i), .f_pred_i(f_pred_i), .f_idx_i(f_idx_i),
    .f_alt_pc_i(f_alt_pc_i), .f_stall_o(f_stall_o),
    .ex_resolve_i(ex_resolve_i), .ex_taken_i(ex_taken_i),
    .upd_valid_o(upd_valid_o), .upd_taken_o(upd_taken_o), .upd_idx_o(upd_idx_o),
    .flush_o(flush_o), .redirect_pc_o(redirect_pc_o), .err_o(err_o),
    .br_cnt_o(br_cnt_o), .mp_cnt_o(mp_cnt_o)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_push(input logic en, input logic pred, input logic [2:0] idx, input logic [9:0] alt);
    f_branch_i = en;
    f_pred_i   = pred;
    f_idx_i    = idx;
    f_alt_pc_i = alt;
  endtask

  initial begin
    rst = 1'b0;
    drive_push(1'b0, 1'b0, 3'd0, 10'h0);
    ex_resolve_i = 1'b0;
    ex_taken_i   = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_stall",    32'(f_stall_o), 32'd0);
    chk("rst_upd_v",    32'(upd_valid_o), 32'd0);
    chk("rst_upd_idx",  32'(upd_idx_o), 32'd0);
    chk("rst_flush",    32'(flush_o), 32'd0);
    chk("rst_redirect", 32'(redirect_pc_o), 32'd0);
    chk("rst_err",      32'(err_o), 32'd0);
    chk("rst_br",       32'(br_cnt_o), 32'd0);
    chk("rst_mp",       32'(mp_cnt_o), 32'd0);
    rst = 1'b1;

    // Fill the queue
    for (int i = 1; i <= 4; i++) begin
      chk("fill_stall_pre", 32'(f_stall_o), 32'd0);
      drive_push(1'b1, 1'b1, 3'(i), 10'(32'h100 + i));
      tick();
    end
    chk("full_stall", 32'(f_stall_o), 32'd1);
    drive_push(1'b1, 1'b1, 3'd7, 10'h1F7);
    tick();
    chk("full_stall_hold", 32'(f_stall_o), 32'd1);
    drive_push(1'b0, 1'b0, 3'd0, 10'h0);

    // Drain with correct predictions
    ex_resolve_i = 1'b1;
    ex_taken_i   = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("drain_upd_v",     32'(upd_valid_o), 32'd1);
      chk("drain_upd_idx",   32'(upd_idx_o), 32'(i));
      chk("drain_upd_taken", 32'(upd_taken_o), 32'd1);
      chk("drain_flush",     32'(flush_o), 32'd0);
      chk("drain_stall",     32'(f_stall_o), 32'd0);
    end
    ex_resolve_i = 1'b0;
    tick();
    chk("idle_upd_v",   32'(upd_valid_o), 32'd0);
    chk("idle_upd_idx", 32'(upd_idx_o), 32'd0);
    chk("idle_err",     32'(err_o), 32'd0);

    // Misprediction with a younger wrong-path entry behind it
    drive_push(1'b1, 1'b1, 3'd5, 10'h2A0);
    tick();
    drive_push(1'b1, 1'b1, 3'd6, 10'h111);
    tick();
    drive_push(1'b1, 1'b0, 3'd3, 10'h0AA);   // push in mispredict cycle
    ex_resolve_i = 1'b1;
    ex_taken_i   = 1'b0;
    tick();
    chk("mp_flush",     32'(flush_o), 32'd1);
    chk("mp_redirect",  32'(redirect_pc_o), 32'h2A0);
    chk("mp_upd_v",     32'(upd_valid_o), 32'd1);
    chk("mp_upd_idx",   32'(upd_idx_o), 32'd5);
    chk("mp_upd_taken", 32'(upd_taken_o), 32'd0);
    drive_push(1'b1, 1'b1, 3'd2, 10'h0BB);   // push during FLUSH
    ex_taken_i = 1'b1;                       // resolve during FLUSH is ignored
    tick();
    chk("post_flush",    32'(flush_o), 32'd0);
    chk("post_upd_v",    32'(upd_valid_o), 32'd0);
    chk("post_err",      32'(err_o), 32'd0);
    chk("post_redirect", 32'(redirect_pc_o), 32'h2A0);
    ex_resolve_i = 1'b0;
    drive_push(1'b1, 1'b0, 3'd7, 10'h155);   // first accepted push
    tick();
    drive_push(1'b0, 1'b0, 3'd0, 10'h0);
    ex_resolve_i = 1'b1;
    ex_taken_i   = 1'b0;
    tick();
    chk("after_upd_v",     32'(upd_valid_o), 32'd1);
    chk("after_upd_idx",   32'(upd_idx_o), 32'd7);
    chk("after_upd_taken", 32'(upd_taken_o), 32'd0);
    chk("after_flush",     32'(flush_o), 32'd0);

    // Resolve with an empty queue
    tick();
    chk("empty_upd_v", 32'(upd_valid_o), 32'd0);
    chk("empty_err",   32'(err_o), 32'd1);
    ex_resolve_i = 1'b0;
    tick();
    tick();
    chk("err_sticky", 32'(err_o), 32'd1);

    // Reset mid-flight
    drive_push(1'b1, 1'b1, 3'd1, 10'h001);
    tick();
    tick();
    drive_push(1'b0, 1'b0, 3'd0, 10'h0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst2_err",      32'(err_o), 32'd0);
    chk("rst2_redirect", 32'(redirect_pc_o), 32'd0);
    chk("rst2_br",       32'(br_cnt_o), 32'd0);
    ex_resolve_i = 1'b1;
    ex_taken_i   = 1'b1;
    tick();
    chk("rst2_upd_v", 32'(upd_valid_o), 32'd0);
    chk("rst2_err_b", 32'(err_o), 32'd1);
    rst = 1'b0;
    ex_resolve_i = 1'b0;
    tick();
    rst = 1'b1;

    // Three correct branches with overlapping push/pop
    drive_push(1'b1, 1'b1, 3'd1, 10'h011);
    tick();
    drive_push(1'b1, 1'b1, 3'd2, 10'h012);
    ex_resolve_i = 1'b1;
    ex_taken_i   = 1'b1;
    tick();
    chk("ov_idx1", 32'(upd_idx_o), 32'd1);
    drive_push(1'b1, 1'b1, 3'd3, 10'h013);
    tick();
    chk("ov_idx2", 32'(upd_idx_o), 32'd2);
    drive_push(1'b0, 1'b0, 3'd0, 10'h0);
    tick();
    chk("ov_idx3", 32'(upd_idx_o), 32'd3);
    ex_resolve_i = 1'b0;
    tick();
    chk("ov_idle", 32'(upd_valid_o), 32'd0);

    // Two mispredictions
    drive_push(1'b1, 1'b1, 3'd4, 10'h3C0);
    tick();
    drive_push(1'b0, 1'b0, 3'd0, 10'h0);
    ex_resolve_i = 1'b1;
    ex_taken_i   = 1'b0;
    tick();
    chk("mp1_flush",    32'(flush_o), 32'd1);
    chk("mp1_redirect", 32'(redirect_pc_o), 32'h3C0);
    ex_resolve_i = 1'b0;
    tick();
    drive_push(1'b1, 1'b0, 3'd5, 10'h3C5);
    tick();
    drive_push(1'b0, 1'b0, 3'd0, 10'h0);
    ex_resolve_i = 1'b1;
    ex_taken_i   = 1'b1;
    tick();
    chk("mp2_flush",     32'(flush_o), 32'd1);
    chk("mp2_redirect",  32'(redirect_pc_o), 32'h3C5);
    chk("mp2_upd_idx",   32'(upd_idx_o), 32'd5);
    chk("mp2_upd_taken", 32'(upd_taken_o), 32'd1);
    ex_resolve_i = 1'b0;
    tick();
    chk("perf_br", 32'(br_cnt_o), EXP_BR);
    chk("perf_mp", 32'(mp_cnt_o), EXP_MP);
    chk("final_err", 32'(err_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
